// File: rtl/video_pkg.sv
// Shared widths, defaults and fetch-tag type for the video pixel fetch path.
package video_pkg;
    localparam int RGB_W         = 12;
    localparam int CIDX_W        = 8;
    localparam int FRAC_W        = 7;
    localparam int HSTEP_DEFAULT = 64;
    localparam int GEN_W         = 2;

    typedef logic [RGB_W-1:0]  rgb_t;
    typedef logic [CIDX_W-1:0] cidx_t;

    // Tag carried by every outstanding read; a generation mismatch marks it stale.
    typedef struct packed {
        logic             valid;
        logic [GEN_W-1:0] gen;
    } fetch_tag_t;

    function automatic logic tag_live(input fetch_tag_t tag, input logic [GEN_W-1:0] gen);
        return tag.valid && (tag.gen == gen);
    endfunction
endpackage

// File: rtl/video_fetch_fifo.sv
// Small synchronous prefetch FIFO: flush, occupancy count and a combinational head.
module video_fetch_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [RGB_W-1:0]       push_data,
    input  logic                   pop,
    output logic [RGB_W-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rgb_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/video_pixel_fetch.sv
// Pixel fetch: ping-pong line buffer read, horizontal scaling, palette lookup and
// a prefetch FIFO feeding palette_rgb_data to the composite stage.
module video_pixel_fetch
    import video_pkg::*;
#(
    parameter int LB_ADDR_W  = 10,
    parameter int HSTEP      = HSTEP_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 next_frame,
    input  logic                 next_line,
    input  logic                 next_pixel,
    input  logic                 vblank_pulse,
    output logic [LB_ADDR_W:0]   lb_rd_addr,
    input  logic [CIDX_W-1:0]    lb_rd_data,
    output logic [CIDX_W-1:0]    pal_rd_addr,
    input  logic [RGB_W-1:0]     pal_rd_data,
    output logic [RGB_W-1:0]     palette_rgb_data,
    output logic                 render_bank,
    output logic [8:0]           disp_line,
    output logic                 underflow
);
    localparam int ACC_W = LB_ADDR_W + FRAC_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ACC_W:0] STEP = (ACC_W + 1)'(HSTEP);

    logic             next_pixel_d;
    logic             disp_bank;
    logic             armed;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [GEN_W-1:0] gen;
    fetch_tag_t       s0_tag;
    fetch_tag_t       s1_tag;

    logic             line_end;
    logic             restart;
    logic             s0_live;
    logic             s1_live;
    logic             push;
    logic             pop;
    logic             issue;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    rgb_t             fifo_head;

    assign line_end    = next_pixel_d & ~next_pixel;
    assign restart     = line_end | vblank_pulse;
    assign render_bank = ~disp_bank;

    assign s0_live = tag_live(s0_tag, gen);
    assign s1_live = tag_live(s1_tag, gen);
    assign push    = s1_live & ~restart;
    assign pop     = next_pixel & ~fifo_empty;

    // Count every entry already owed to the FIFO so an issued read always finds room.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(s0_live) + OCC_W'(s1_live) - OCC_W'(pop);
    assign issue     = armed & ~restart & (occupancy < OCC_W'(FIFO_DEPTH));
    assign acc_sum   = {1'b0, acc} + STEP;

    assign palette_rgb_data = (next_pixel && !fifo_empty) ? fifo_head : '0;

    video_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (restart),
        .push     (push),
        .push_data(pal_rd_data),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Line/field bookkeeping: bank swap at line end, arming and generation bump on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_pixel_d <= 1'b0;
            disp_bank    <= 1'b0;
            armed        <= 1'b0;
            gen          <= '0;
        end else begin
            next_pixel_d <= next_pixel;
            if (vblank_pulse) begin
                disp_bank <= 1'b0;
            end else if (line_end) begin
                disp_bank <= ~disp_bank;
            end
            if (restart) begin
                armed <= 1'b1;
                gen   <= gen + 1'b1;
            end
        end
    end

    // Fetch pipeline; the accumulator saturates instead of wrapping past the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            lb_rd_addr  <= '0;
            pal_rd_addr <= '0;
            s0_tag      <= '0;
            s1_tag      <= '0;
        end else begin
            if (restart) begin
                acc <= '0;
            end else if (issue) begin
                acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            end
            if (issue) begin
                lb_rd_addr <= {disp_bank, acc[ACC_W-1:FRAC_W]};
            end
            s0_tag.valid <= issue;
            s0_tag.gen   <= gen;
            s1_tag       <= s0_tag;
            if (s0_live) begin
                pal_rd_addr <= lb_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (vblank_pulse) begin
            underflow <= 1'b0;
        end else if (next_pixel && fifo_empty && armed) begin
            underflow <= 1'b1;
        end
    end

    // A frame start wins over a coincident line advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_line <= '0;
        end else if (next_frame) begin
            disp_line <= '0;
        end else if (next_line && (disp_line != 9'd511)) begin
            disp_line <= disp_line + 9'd1;
        end
    end
endmodule

// File: doc/video_pixel_fetch.md
Name: video_pixel_fetch

Overview:
- Upstream feeder of the composite timing/modulator stage. Supplies the 12-bit palette_rgb_data that the composite stage samples on every clock where next_pixel is high.
- Reads 8-bit colour indices from a double-banked (ping-pong) line buffer, scales them horizontally with a fixed-point address accumulator, and looks them up in a 256x12 palette RAM.
- Pushes results into a small prefetch FIFO so data is ready on the first active clock.
- Tells the renderer which bank to fill and which display line is current.

Parameters:
- LB_ADDR_W, 10, line-buffer x address width per bank.
- HSTEP, 64, source pixels per output clock in 1.7 fixed point. 64 gives 640 source pixels over 1280 active clocks.
- FIFO_DEPTH, 4, prefetch FIFO entries. Must be a power of 2 and at least 4.

Ports:
- clk  in  1  pixel clock, same as the composite stage.
- rst_n  in  1  asynchronous, active-low reset.
- next_frame  in  1  first-visible-line pulse from the composite stage.
- next_line  in  1  one clock before active pixels, every line.
- next_pixel  in  1  high during the horizontal active window, every line.
- vblank_pulse  in  1  end-of-field pulse.
- lb_rd_addr  out  LB_ADDR_W+1  {bank, x}; the external line buffer returns data 1 clock later.
- lb_rd_data  in  8  colour index.
- pal_rd_addr  out  8  palette read address; the palette returns data 1 clock later.
- pal_rd_data  in  12  RGB444.
- palette_rgb_data  out  12  pixel to the composite stage.
- render_bank  out  1  bank the renderer must fill (equals ~disp_bank).
- disp_line  out  9  visible-line index for the renderer.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): all of the following are cleared.
  - disp_bank=0, so render_bank=1.
  - disp_line=0, underflow=0, armed=0.
  - FIFO empty, in-flight count=0, x accumulator=0.
  - palette_rgb_data=0, lb_rd_addr=0, pal_rd_addr=0.
- Restart event: rises on a falling edge of next_pixel (line_end, from a registered copy) or on vblank_pulse.
  - Flush FIFO and discard in-flight reads; a generation tag invalidates them.
  - Clear the accumulator and set armed=1.
  - line_end toggles disp_bank.
  - vblank_pulse forces disp_bank=0. vblank_pulse and line_end never coincide (pulses are many clocks apart).
- Fetch pipeline, 3 stages, no stalls:
  - S0: when issue is allowed, drive lb_rd_addr={disp_bank, acc[LB_ADDR_W+6:7]}, then acc += HSTEP.
  - S1: pal_rd_addr=lb_rd_data.
  - S2: push pal_rd_data into the FIFO.
  - Total fetch latency is 2 clocks.
- Issue rule: issue when armed and (fifo_count + inflight - pop) < FIFO_DEPTH, so overflow is impossible.
  - Throughput is one entry per clock in steady state.
  - The blanking interval (at least 190 clocks) refills the FIFO before next_pixel rises.
- Address saturation: the x integer part saturates at 2^LB_ADDR_W-1; it never wraps within a line.
- Output:
  - When next_pixel=1 and the FIFO is non-empty: palette_rgb_data = FIFO head (registered storage, combinational mux), and the head is popped.
  - When next_pixel=0: palette_rgb_data=0 and nothing is popped.
  - When next_pixel=1 and the FIFO is empty: output 0. If armed, set underflow.
- underflow clears only on vblank_pulse or reset. If an underflow and vblank_pulse coincide, clear wins.
- disp_line:
  - Cleared on next_frame.
  - Otherwise increments on next_line, saturating at 511.
  - If next_frame and next_line coincide, the result is 0.
- Reset mid-line: the block stays idle (armed=0) and outputs 0 with no underflow until the first restart event.

Decomposition:
- Shared package video_pkg holds:
  - RGB444 width.
  - Colour-index width 8.
  - Fixed-point fraction width 7.
  - Default HSTEP.
- One sub-module: video_fetch_fifo (synchronous FIFO with flush, count output, combinational head).

Test Plan:
- Reset then a 1280-clock next_pixel window, linebuf[x]=x[7:0], pal[i]={i[3:0],i[3:0],i[3:0]}, HSTEP=64 → pixels 0,0 give 0x000, 0x000; pixels 2,3 give 0x111, 0x111; pixel 1279 gives 0xFFF (x=639); no underflow.
- Two consecutive lines → lb_rd_addr MSB toggles 0→1; render_bank toggles 1→0 at the next_pixel fall.
- HSTEP=128 → each output clock advances x by 1; addresses saturate at x=1023 and hold there for clocks 1023-1279.
- Hold the FIFO empty by asserting next_pixel immediately after reset then a restart with <2 clocks gap → underflow=1 and output 0; the next vblank_pulse clears it.
- next_frame and next_line in the same cycle with disp_line=37 → disp_line=0. The following next_line gives 1.
- Assert rst_n=0 mid-line while the FIFO holds 3 entries → outputs 0 immediately. After release, no fetch occurs until line_end.
